// File: rtl/exc_sequencer.sv
// Exception sequencer: fixed-priority arbitration, EPC write, vector-byte fetch, PC load.
// Optional statistics (per-cause counters, drop strobe) are built when EXC_STATS_EN is defined.
`timescale 1ns/1ps
module exc_sequencer #(
   parameter logic [31:0] VEC_OPCODE = 32'd253,
   parameter logic [31:0] VEC_OVF    = 32'd254,
   parameter logic [31:0] VEC_DIV0   = 32'd255,
   parameter int          MEM_LAT    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_opcode_i,
   input  logic        exc_ovf_i,
   input  logic        exc_div0_i,
   input  logic [31:0] epc_value_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_addr_o,
   output logic        mem_rd_o,
   output logic        epc_we_o,
   output logic [31:0] epc_data_o,
   output logic        pc_load_o,
   output logic [31:0] pc_data_o,
   output logic        hold_o,
   output logic        ack_o,
`ifdef EXC_STATS_EN
   output logic [7:0]  cnt_opcode_o,
   output logic [7:0]  cnt_ovf_o,
   output logic [7:0]  cnt_div0_o,
   output logic        drop_o,
`endif
   output logic [1:0]  cause_o
);

   // An out-of-range latency is treated as a single-cycle memory.
   localparam int         LAT_EFF  = (MEM_LAT < 1 || MEM_LAT > 15) ? 1 : MEM_LAT;
   localparam logic [3:0] LAT_INIT = 4'(LAT_EFF - 1);

   typedef enum logic [2:0] {IDLE, SAVE, READ, LOAD, DONE} state_t;

   state_t      state;
   logic [31:0] vecReg;
   logic [3:0]  latCnt;
   logic        anyReq;
   logic [1:0]  winCause;
   logic [31:0] winVec;
   logic        unusedMemBits;

   assign unusedMemBits = ^mem_data_i[31:8];
   assign anyReq        = exc_opcode_i | exc_ovf_i | exc_div0_i;

   always_comb begin
      winCause = 2'b00;
      winVec   = 32'd0;
      if (exc_opcode_i) begin
         winCause = 2'b01;
         winVec   = VEC_OPCODE;
      end else if (exc_ovf_i) begin
         winCause = 2'b10;
         winVec   = VEC_OVF;
      end else if (exc_div0_i) begin
         winCause = 2'b11;
         winVec   = VEC_DIV0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         vecReg     <= 32'd0;
         latCnt     <= 4'd0;
         mem_addr_o <= 32'd0;
         mem_rd_o   <= 1'b0;
         epc_we_o   <= 1'b0;
         epc_data_o <= 32'd0;
         pc_load_o  <= 1'b0;
         pc_data_o  <= 32'd0;
         hold_o     <= 1'b0;
         ack_o      <= 1'b0;
         cause_o    <= 2'b00;
      end else begin
         epc_we_o  <= 1'b0;
         pc_load_o <= 1'b0;
         ack_o     <= 1'b0;
         case (state)
            IDLE: begin
               if (anyReq) begin
                  state      <= SAVE;
                  hold_o     <= 1'b1;
                  epc_we_o   <= 1'b1;
                  epc_data_o <= epc_value_i;
                  cause_o    <= winCause;
                  vecReg     <= winVec;
               end
            end
            SAVE: begin
               state      <= READ;
               mem_rd_o   <= 1'b1;
               mem_addr_o <= vecReg;
               latCnt     <= LAT_INIT;
            end
            READ: begin
               if (latCnt == 4'd0) begin
                  state     <= LOAD;
                  pc_load_o <= 1'b1;
                  pc_data_o <= {24'd0, mem_data_i[7:0]};
               end else begin
                  latCnt <= latCnt - 4'd1;
               end
            end
            LOAD: begin
               state    <= DONE;
               mem_rd_o <= 1'b0;
               ack_o    <= 1'b1;
            end
            DONE: begin
               state      <= IDLE;
               hold_o     <= 1'b0;
               mem_addr_o <= 32'd0;
               pc_data_o  <= 32'd0;
            end
            default: begin
               state  <= IDLE;
               hold_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef EXC_STATS_EN
   function automatic logic [7:0] satInc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Counters follow the arbitration result at the moment a request is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_opcode_o <= 8'd0;
         cnt_ovf_o    <= 8'd0;
         cnt_div0_o   <= 8'd0;
         drop_o       <= 1'b0;
      end else begin
         drop_o <= anyReq && hold_o && (state != DONE);
         if (state == IDLE && anyReq) begin
            case (winCause)
               2'b01:   cnt_opcode_o <= satInc(cnt_opcode_o);
               2'b10:   cnt_ovf_o    <= satInc(cnt_ovf_o);
               2'b11:   cnt_div0_o   <= satInc(cnt_div0_o);
               default: ;
            endcase
         end
      end
   end
`endif

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: one instance at MEM_LAT=1 and one at MEM_LAT=3
// share the request inputs; each has its own vector memory and expected-event queue.
`timescale 1ns/1ps
module tb_exc_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        excOpc, excOvf, excDiv0;
   logic [31:0] epcVal;
   logic [31:0] memData1, memData3;
   logic [31:0] addr1, epcData1, pcData1, addr3, epcData3, pcData3;
   logic        rd1, epcWe1, pcLoad1, hold1, ack1;
   logic        rd3, epcWe3, pcLoad3, hold3, ack3;
   logic [1:0]  cause1, cause3;
`ifdef EXC_STATS_EN
   logic [7:0]  cntOpc1, cntOvf1, cntDiv1, cntOpc3, cntOvf3, cntDiv3;
   logic        drop1, drop3;
`endif

   exc_sequencer #(.MEM_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .exc_opcode_i(excOpc), .exc_ovf_i(excOvf),
      .exc_div0_i(excDiv0), .epc_value_i(epcVal), .mem_data_i(memData1),
      .mem_addr_o(addr1), .mem_rd_o(rd1), .epc_we_o(epcWe1), .epc_data_o(epcData1),
      .pc_load_o(pcLoad1), .pc_data_o(pcData1), .hold_o(hold1), .ack_o(ack1),
`ifdef EXC_STATS_EN
      .cnt_opcode_o(cntOpc1), .cnt_ovf_o(cntOvf1), .cnt_div0_o(cntDiv1), .drop_o(drop1),
`endif
      .cause_o(cause1));

   exc_sequencer #(.MEM_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .exc_opcode_i(excOpc), .exc_ovf_i(excOvf),
      .exc_div0_i(excDiv0), .epc_value_i(epcVal), .mem_data_i(memData3),
      .mem_addr_o(addr3), .mem_rd_o(rd3), .epc_we_o(epcWe3), .epc_data_o(epcData3),
      .pc_load_o(pcLoad3), .pc_data_o(pcData3), .hold_o(hold3), .ack_o(ack3),
`ifdef EXC_STATS_EN
      .cnt_opcode_o(cntOpc3), .cnt_ovf_o(cntOvf3), .cnt_div0_o(cntDiv3), .drop_o(drop3),
`endif
      .cause_o(cause3));

   // Vector table; upper bits are junk so zero-extension is visible.
   function automatic logic [7:0] memByte(input logic [31:0] a);
      case (a)
         32'd253: return 8'h3C;
         32'd254: return 8'h80;
         32'd255: return 8'hA5;
         default: return 8'h00;
      endcase
   endfunction
   assign memData1 = {24'hDEADBE, memByte(addr1)};
   assign memData3 = {24'hDEADBE, memByte(addr3)};

   typedef struct {
      int          kind;   // 0 epc write, 1 read start, 2 pc load, 3 ack
      int          cyc;
      logic [31:0] data;
   } ev_t;

   ev_t q1[$];
   ev_t q3[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic popCheck(input int which, input int kind, input logic [31:0] data,
                           input string name);
      ev_t e;
      int  sz;
      sz = (which == 0) ? q1.size() : q3.size();
      if (sz == 0) begin
         checks++;
         errors++;
         $display("FAIL %s unexpected event at cycle %0d actual=%h required=none", name, cyc, data);
      end else begin
         if (which == 0) e = q1.pop_front();
         else            e = q3.pop_front();
         check({name, " kind"}, kind, e.kind);
         check({name, " cycle"}, cyc, e.cyc);
         check({name, " data"}, data, e.data);
      end
   endtask

   task automatic pushSeq(input int which, input int c0, input int lat, input logic [31:0] epc,
                          input logic [31:0] vec, input logic [31:0] pcv, input logic [1:0] cause);
      ev_t e[4];
      e[0] = '{kind: 0, cyc: c0 + 1,       data: epc};
      e[1] = '{kind: 1, cyc: c0 + 2,       data: vec};
      e[2] = '{kind: 2, cyc: c0 + 2 + lat, data: pcv};
      e[3] = '{kind: 3, cyc: c0 + 3 + lat, data: 32'(cause)};
      for (int i = 0; i < 4; i++) begin
         if (which == 0) q1.push_back(e[i]);
         else            q3.push_back(e[i]);
      end
   endtask

   // Monitors: any strobe or read start pops the matching expectation.
   logic prevRd1 = 1'b0, prevRd3 = 1'b0;
   always @(negedge clk) begin
      if (epcWe1)          popCheck(0, 0, epcData1, "lat1 epc");
      if (rd1 && !prevRd1) popCheck(0, 1, addr1, "lat1 rd");
      if (pcLoad1)         popCheck(0, 2, pcData1, "lat1 pc");
      if (ack1)            popCheck(0, 3, 32'(cause1), "lat1 ack");
      prevRd1 = rd1;
   end
   always @(negedge clk) begin
      if (epcWe3)          popCheck(1, 0, epcData3, "lat3 epc");
      if (rd3 && !prevRd3) popCheck(1, 1, addr3, "lat3 rd");
      if (pcLoad3)         popCheck(1, 2, pcData3, "lat3 pc");
      if (ack3)            popCheck(1, 3, 32'(cause3), "lat3 ack");
      prevRd3 = rd3;
   end

   task automatic waitIdle(input string name);
      int n = 0;
      while ((hold1 || hold3) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (hold1 || hold3) check({name, " idle timeout"}, 32'(hold1 | hold3), 32'd0);
   endtask

   task automatic runSeq(input logic o, input logic v, input logic d, input logic [31:0] epc,
                         input logic [31:0] vec, input logic [31:0] pcv, input logic [1:0] cause,
                         input string name);
      int c0;
      @(posedge clk); #1;
      check({name, " hold before"}, 32'(hold1), 32'd0);
      excOpc = o; excOvf = v; excDiv0 = d; epcVal = epc;
      c0 = cyc;
      pushSeq(0, c0, 1, epc, vec, pcv, cause);
      pushSeq(1, c0, 3, epc, vec, pcv, cause);
      @(posedge clk); #1;
      excOpc = 1'b0; excOvf = 1'b0; excDiv0 = 1'b0;
      check({name, " hold C1"}, 32'(hold1), 32'd1);
      waitIdle(name);
   endtask

   task automatic checkIdle(input string name, input logic [31:0] epc, input logic [1:0] cause);
      check({name, " idle epc1"}, epcData1, epc);
      check({name, " idle cause1"}, 32'(cause1), 32'(cause));
      check({name, " idle addr1"}, addr1, 32'd0);
      check({name, " idle pcdata1"}, pcData1, 32'd0);
      check({name, " idle cause3"}, 32'(cause3), 32'(cause));
      check({name, " idle hold3"}, 32'(hold3), 32'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL global timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int c0;
      reset = 1'b0;
      excOpc = 1'b0; excOvf = 1'b0; excDiv0 = 1'b0;
      epcVal = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst hold", 32'(hold1), 32'd0);
      check("rst outputs", {28'd0, rd1, epcWe1, pcLoad1, ack1}, 32'd0);
      check("rst buses", addr1 | epcData1 | pcData1, 32'd0);
      check("rst cause", 32'(cause1), 32'd0);
      check("rst hold3", 32'(hold3), 32'd0);
      reset = 1'b1;

      runSeq(1'b0, 1'b1, 1'b0, 32'h40, 32'd254, 32'h80, 2'b10, "ovf alone");
      checkIdle("ovf alone", 32'h40, 2'b10);

      runSeq(1'b1, 1'b1, 1'b1, 32'h100, 32'd253, 32'h3C, 2'b01, "all three");
      checkIdle("all three", 32'h100, 2'b01);

      runSeq(1'b0, 1'b0, 1'b1, 32'h200, 32'd255, 32'hA5, 2'b11, "div0");
      checkIdle("div0", 32'h200, 2'b11);

      // div0 raised mid-sequence is ignored, then starts a second sequence from IDLE
      @(posedge clk); #1;
      excOpc = 1'b1; epcVal = 32'h300;
      c0 = cyc;
      pushSeq(0, c0, 1, 32'h300, 32'd253, 32'h3C, 2'b01);
      pushSeq(1, c0, 3, 32'h300, 32'd253, 32'h3C, 2'b01);
      pushSeq(0, c0 + 5, 1, 32'h304, 32'd255, 32'hA5, 2'b11);
      pushSeq(1, c0 + 7, 3, 32'h304, 32'd255, 32'hA5, 2'b11);
      @(posedge clk); #1;
      excOpc = 1'b0;
      @(posedge clk); #1;
      excDiv0 = 1'b1; epcVal = 32'h304;
      @(posedge clk); #1;
      check("late div0 cause C3", 32'(cause1), 32'd1);
      while (cyc < c0 + 8) begin
         @(posedge clk); #1;
      end
      excDiv0 = 1'b0;
      waitIdle("late div0");
      checkIdle("late div0", 32'h304, 2'b11);

      // reset mid-sequence: only the EPC write may be seen
      @(posedge clk); #1;
      excOvf = 1'b1; epcVal = 32'h500;
      c0 = cyc;
      q1.push_back('{kind: 0, cyc: c0 + 1, data: 32'h500});
      q3.push_back('{kind: 0, cyc: c0 + 1, data: 32'h500});
      @(posedge clk); #1;
      excOvf = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("midrst hold", 32'(hold1), 32'd0);
      check("midrst strobes", {28'd0, rd1, epcWe1, pcLoad1, ack1}, 32'd0);
      check("midrst buses", addr1 | epcData1 | pcData1, 32'd0);
      check("midrst cause", 32'(cause1), 32'd0);
      check("midrst hold3", 32'(hold3), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("after midrst hold", 32'(hold1), 32'd0);

`ifdef EXC_STATS_EN
      for (int i = 0; i < 300; i++)
         runSeq(1'b0, 1'b1, 1'b0, 32'h600, 32'd254, 32'h80, 2'b10, "stats ovf");
      check("stats cnt ovf", 32'(cntOvf1), 32'hFF);
      check("stats cnt opc", 32'(cntOpc1), 32'd0);
      check("stats cnt ovf3", 32'(cntOvf3), 32'hFF);
      @(posedge clk); #1;
      excOpc = 1'b1; epcVal = 32'h700;
      c0 = cyc;
      pushSeq(0, c0, 1, 32'h700, 32'd253, 32'h3C, 2'b01);
      pushSeq(1, c0, 3, 32'h700, 32'd253, 32'h3C, 2'b01);
      @(posedge clk); #1;
      excOpc = 1'b0;
      check("stats no drop", 32'(drop1), 32'd0);
      @(posedge clk); #1;
      excDiv0 = 1'b1;
      @(posedge clk); #1;
      excDiv0 = 1'b0;
      check("stats drop", 32'(drop1), 32'd1);
      @(posedge clk); #1;
      check("stats drop end", 32'(drop1), 32'd0);
      waitIdle("stats drop");
      check("stats cnt opc after", 32'(cntOpc1), 32'd1);
      check("stats cnt div0", 32'(cntDiv1), 32'd0);
`endif

      repeat (4) @(posedge clk);
      #1;
      check("queue1 drained", q1.size(), 32'd0);
      check("queue3 drained", q3.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
